// File: rtl/beta_rf_seq.sv
// Beta register-file port sequencer: launches reads, hands operands to execute, sequences writeback.
// Optional build macro RF_SKIP_R31_WR_EN: suppress non-exception writes to R31.
module beta_rf_seq #(
  parameter int         RD_LAT  = 2,
  parameter int         WD_HOLD = 2,
  parameter logic [5:0] ST_OP   = 6'h19
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [4:0]  ra,
  output logic [4:0]  rb,
  output logic [4:0]  rc,
  output logic        ra2sel,
  output logic        wasel,
  output logic        werf,
  output logic [31:0] wdata,
  input  logic [31:0] radata,
  input  logic [31:0] rbdata,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op_rc,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic        res_exc,
  output logic        res_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_OP_OUT  = 3'd2,
    S_WB_WAIT = 3'd3,
    S_WR_HOLD = 3'd4
  } state_t;

`ifdef RF_SKIP_R31_WR_EN
  localparam bit SKIP_R31 = 1'b1;
`else
  localparam bit SKIP_R31 = 1'b0;
`endif

  localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
  localparam logic [7:0] WD_LAST = 8'(WD_HOLD - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic       is_st_reg;
  logic       skip_wr;
  logic       unused_inst;

  // Literal field [10:0] is not needed on this port.
  assign unused_inst = ^inst[10:0];
  assign skip_wr     = SKIP_R31 && (rc == 5'd31);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      is_st_reg  <= 1'b0;
      inst_ready <= 1'b1;
      ra         <= '0;
      rb         <= '0;
      rc         <= '0;
      ra2sel     <= 1'b0;
      wasel      <= 1'b0;
      werf       <= 1'b0;
      wdata      <= '0;
      op_valid   <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_rc      <= '0;
      res_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (inst_valid && inst_ready) begin
            ra         <= inst[20:16];
            rb         <= inst[15:11];
            rc         <= inst[25:21];
            ra2sel     <= (inst[31:26] == ST_OP);
            is_st_reg  <= (inst[31:26] == ST_OP);
            werf       <= 1'b0;
            wasel      <= 1'b0;
            cnt_reg    <= '0;
            inst_ready <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (cnt_reg == RD_LAST) begin
            op_a      <= radata;
            op_b      <= rbdata;
            op_rc     <= rc;
            op_valid  <= 1'b1;
            state_reg <= S_OP_OUT;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        S_OP_OUT: begin
          if (op_valid && op_ready) begin
            op_valid  <= 1'b0;
            res_ready <= 1'b1;
            state_reg <= S_WB_WAIT;
          end
        end

        S_WB_WAIT: begin
          if (res_valid) begin
            wdata     <= res_data;
            res_ready <= 1'b0;
            cnt_reg   <= '0;
            if (res_exc) begin
              wasel     <= 1'b1;
              werf      <= 1'b1;
              state_reg <= S_WR_HOLD;
            end else if (is_st_reg || skip_wr) begin
              // Nothing to write: release straight back to fetch.
              inst_ready <= 1'b1;
              busy       <= 1'b0;
              state_reg  <= S_IDLE;
            end else begin
              wasel     <= 1'b0;
              werf      <= 1'b1;
              state_reg <= S_WR_HOLD;
            end
          end
        end

        S_WR_HOLD: begin
          werf <= 1'b0;
          if (cnt_reg == WD_LAST) begin
            wasel      <= 1'b0;
            inst_ready <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        default: begin
          inst_ready <= 1'b1;
          busy       <= 1'b0;
          op_valid   <= 1'b0;
          res_ready  <= 1'b0;
          werf       <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beta_rf_seq.sv
// Directed bench for beta_rf_seq with a negedge-written register-file model.
module tb_beta_rf_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [4:0]  ra, rb, rc;
  logic        ra2sel, wasel, werf;
  logic [31:0] wdata, radata, rbdata;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rc;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_exc;
  logic        res_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

`ifdef RF_SKIP_R31_WR_EN
  localparam bit SKIP31 = 1'b1;
`else
  localparam bit SKIP31 = 1'b0;
`endif

  always #5 clock = ~clock;

  beta_rf_seq dut (
    .clock(clock), .reset_n(reset_n),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .ra(ra), .rb(rb), .rc(rc), .ra2sel(ra2sel), .wasel(wasel), .werf(werf),
    .wdata(wdata), .radata(radata), .rbdata(rbdata),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_rc(op_rc),
    .res_valid(res_valid), .res_data(res_data), .res_exc(res_exc), .res_ready(res_ready),
    .busy(busy)
  );

  // Register-file model: writes on negedge, combinational reads, R31 reads as zero.
  logic [31:0] rf [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic [4:0]  rb_addr;

  always @(negedge clock) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (werf) rf[wasel ? 5'd30 : rc] <= wdata;
  end

  assign rb_addr = ra2sel ? rc : rb;
  assign radata  = (ra == 5'd31) ? 32'd0 : rf[ra];
  assign rbdata  = (rb_addr == 5'd31) ? 32'd0 : rf[rb_addr];

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    return (a == 5'd31) ? 32'd0 : rf[a];
  endfunction

  function automatic logic [31:0] mk_inst(input logic [5:0] op, input logic [4:0] c,
                                          input logic [4:0] a, input logic [4:0] b);
    return {op, c, a, b, 11'h0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] res_data;
    logic        res_exc;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_ra2sel;
    logic        exp_we;
    logic        exp_wasel;
    logic [4:0]  chk_addr;
    logic [31:0] chk_val;
    logic [4:0]  chk2_addr;
    logic [31:0] chk2_val;
  } vec_t;

  vec_t vecs[6];

  // Full transaction starting from IDLE, just after a posedge.
  task automatic run_txn(input int idx, input vec_t v, input int stall);
    chk("inst_ready_idle", {31'd0, inst_ready}, 32'd1);
    inst = v.inst; inst_valid = 1'b1;
    tick();                                   // accept edge t
    inst_valid = 1'b1; inst = 32'hFFFF_FFFF;  // must be ignored while busy
    chk("ra", {27'd0, ra}, {27'd0, v.inst[20:16]});
    chk("rb", {27'd0, rb}, {27'd0, v.inst[15:11]});
    chk("rc", {27'd0, rc}, {27'd0, v.inst[25:21]});
    chk("ra2sel", {31'd0, ra2sel}, {31'd0, v.exp_ra2sel});
    chk("inst_ready_busy", {31'd0, inst_ready}, 32'd0);
    chk("busy", {31'd0, busy}, 32'd1);
    tick();                                   // t+1
    inst_valid = 1'b0;
    chk("op_valid_t1", {31'd0, op_valid}, 32'd0);
    tick();                                   // t+2
    chk("op_valid_t2", {31'd0, op_valid}, 32'd1);
    chk("op_a", op_a, v.exp_a);
    chk("op_b", op_b, v.exp_b);
    chk("op_rc", {27'd0, op_rc}, {27'd0, v.inst[25:21]});
    res_valid = (stall > 0); res_data = 32'hBAD0_BAD0; res_exc = 1'b1;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_op_valid", {31'd0, op_valid}, 32'd1);
      chk("stall_op_a", op_a, v.exp_a);
      chk("stall_op_b", op_b, v.exp_b);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_inst_ready", {31'd0, inst_ready}, 32'd0);
      chk("stall_werf", {31'd0, werf}, 32'd0);
    end
    res_valid = 1'b0;
    op_ready = 1'b1;
    tick();                                   // operand accept
    op_ready = 1'b0;
    chk("op_valid_drop", {31'd0, op_valid}, 32'd0);
    chk("res_ready", {31'd0, res_ready}, 32'd1);
    res_valid = 1'b1; res_data = v.res_data; res_exc = v.res_exc;
    tick();                                   // edge w
    res_valid = 1'b0; res_exc = 1'b0;
    chk("werf_w", {31'd0, werf}, {31'd0, v.exp_we});
    chk("wdata", wdata, v.res_data);
    chk("res_ready_drop", {31'd0, res_ready}, 32'd0);
    if (v.exp_we) begin
      chk("wasel_w", {31'd0, wasel}, {31'd0, v.exp_wasel});
      tick();                                 // w+1
      chk("werf_w1", {31'd0, werf}, 32'd0);
      chk("busy_hold", {31'd0, busy}, 32'd1);
      chk("wasel_hold", {31'd0, wasel}, {31'd0, v.exp_wasel});
      tick();                                 // w+2
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("wasel_clr", {31'd0, wasel}, 32'd0);
    end else begin
      chk("busy_nowr", {31'd0, busy}, 32'd0);
      chk("inst_ready_nowr", {31'd0, inst_ready}, 32'd1);
    end
    chk("rf_chk", rf_rd(v.chk_addr), v.chk_val);
    chk("rf_chk2", rf_rd(v.chk2_addr), v.chk2_val);
    $display("txn %0d inst=%08h op_a=%08h op_b=%08h werf_expected=%0d checks=%0d",
             idx, v.inst, op_a, op_b, v.exp_we, checks);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; inst_valid = 1'b0; inst = '0; op_ready = 1'b0;
    res_valid = 1'b0; res_data = '0; res_exc = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    for (int i = 0; i < 32; i++) preload(5'(i), 32'd0);
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    preload(5'd4, 32'd9);
    preload(5'd6, 32'hAA);

    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_werf", {31'd0, werf}, 32'd0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_res_ready", {31'd0, res_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    vecs[0] = '{mk_inst(6'h20, 5'd3, 5'd1, 5'd2), 32'd12, 1'b0, 32'd5, 32'd7, 1'b0,
                1'b1, 1'b0, 5'd3, 32'd12, 5'd30, 32'd0};
    vecs[1] = '{mk_inst(6'h20, 5'd5, 5'd3, 5'd3), 32'h55, 1'b0, 32'd12, 32'd12, 1'b0,
                1'b1, 1'b0, 5'd5, 32'h55, 5'd3, 32'd12};
    vecs[2] = '{mk_inst(6'h19, 5'd4, 5'd1, 5'd2), 32'h77, 1'b0, 32'd5, 32'd9, 1'b1,
                1'b0, 1'b0, 5'd4, 32'd9, 5'd30, 32'd0};
    vecs[3] = '{mk_inst(6'h20, 5'd6, 5'd2, 5'd1), 32'h104, 1'b1, 32'd7, 32'd5, 1'b0,
                1'b1, 1'b1, 5'd30, 32'h104, 5'd6, 32'hAA};
    vecs[4] = '{mk_inst(6'h20, 5'd31, 5'd31, 5'd1), 32'h99, 1'b0, 32'd0, 32'd5, 1'b0,
                !SKIP31, 1'b0, 5'd30, 32'h104, 5'd1, 32'd5};
    vecs[5] = '{mk_inst(6'h19, 5'd4, 5'd2, 5'd1), 32'h200, 1'b1, 32'd7, 32'd9, 1'b1,
                1'b1, 1'b1, 5'd30, 32'h200, 5'd4, 32'd9};

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i], 0);

    // Operand stall of five cycles with a stray res_valid that must be ignored.
    run_txn(6, vecs[1], 5);

    // Asynchronous reset while the write is in flight.
    inst = mk_inst(6'h20, 5'd7, 5'd1, 5'd2); inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    res_valid = 1'b1; res_data = 32'hDEAD_BEEF; res_exc = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("pre_rst_werf", {31'd0, werf}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_werf", {31'd0, werf}, 32'd0);
    chk("arst_wdata", wdata, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("arst_addr", {17'd0, ra, rb, rc}, 32'd0);
    chk("arst_ops", op_a | op_b, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("post_rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    $display("txn 7 reset during write hold checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
